// File: rtl/inst_decode_stage_if.sv
// Fetch-to-decode and decode-to-execute signal bundle for inst_decode_stage.
// The slave modport is the decode stage itself; master is its environment.
interface inst_decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst_in;
  logic [XLEN-1:0] pc_in;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] pc_out;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm;
  logic [2:0]      fmt;
  logic            illegal;

  modport slave (
    input  in_valid, inst_in, pc_in, out_ready,
    output in_ready, out_valid, pc_out, opcode, rd, rs1, rs2,
           funct3, funct7, imm, fmt, illegal
  );

  modport master (
    output in_valid, inst_in, pc_in, out_ready,
    input  in_ready, out_valid, pc_out, opcode, rd, rs1, rs2,
           funct3, funct7, imm, fmt, illegal
  );
endinterface

// File: rtl/inst_decode_stage.sv
// Registered RV32I decode stage with a two-entry output/skid buffer and flush.
// Optional macro DECODE_ILLEGAL_CHECK_EN enables the illegal-instruction flag.
module inst_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  inst_decode_stage_if.slave   bus
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [2:0] FMT_X = 3'd7;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [34:0] I_OPS = {OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_FENCE};
  localparam logic [13:0] U_OPS = {OP_LUI, OP_AUIPC};

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } dec_t;

  logic [31:0] inst;
  logic [6:0]  op;
  logic [4:0]  i_hit;
  logic [1:0]  u_hit;
  logic        is_i;
  logic        is_u;

  assign inst = bus.inst_in;
  assign op   = inst[6:0];

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_i_ops
      assign i_hit[gi] = (op == I_OPS[gi*7 +: 7]);
    end
    for (gi = 0; gi < 2; gi++) begin : g_u_ops
      assign u_hit[gi] = (op == U_OPS[gi*7 +: 7]);
    end
  endgenerate

  assign is_i = |i_hit;
  assign is_u = |u_hit;

  dec_t        dec;
  logic [31:0] imm32;
  logic        illegal_c;

  // Immediates are first assembled as sign-extended 32-bit values, then widened.
  always_comb begin
    dec   = '0;
    imm32 = '0;
    dec.pc  = bus.pc_in;
    dec.fmt = FMT_X;
    if (is_i) begin
      dec.fmt    = FMT_I;
      dec.rd     = inst[11:7];
      dec.rs1    = inst[19:15];
      dec.funct3 = inst[14:12];
      imm32      = {{20{inst[31]}}, inst[31:20]};
    end else if (is_u) begin
      dec.fmt = FMT_U;
      dec.rd  = inst[11:7];
      imm32   = {inst[31:12], 12'b0};
    end else begin
      case (op)
        OP_STORE: begin
          dec.fmt    = FMT_S;
          dec.rs1    = inst[19:15];
          dec.rs2    = inst[24:20];
          dec.funct3 = inst[14:12];
          imm32      = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        end
        OP_REG: begin
          dec.fmt    = FMT_R;
          dec.rd     = inst[11:7];
          dec.rs1    = inst[19:15];
          dec.rs2    = inst[24:20];
          dec.funct3 = inst[14:12];
          dec.funct7 = inst[31:25];
        end
        OP_BRANCH: begin
          dec.fmt    = FMT_B;
          dec.rs1    = inst[19:15];
          dec.rs2    = inst[24:20];
          dec.funct3 = inst[14:12];
          imm32      = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        end
        OP_JAL: begin
          dec.fmt = FMT_J;
          dec.rd  = inst[11:7];
          imm32   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        end
        default: dec.fmt = FMT_X;
      endcase
    end
    if (dec.fmt != FMT_X) begin
      dec.opcode = op;
    end
    dec.imm     = XLEN'($signed(imm32));
    dec.illegal = illegal_c;
  end

`ifdef DECODE_ILLEGAL_CHECK_EN
  // Only funct7 0000000 and 0100000 exist for base-ISA register ops.
  assign illegal_c = (!is_i && !is_u && !(op inside {OP_STORE, OP_REG, OP_BRANCH, OP_JAL}))
                  || (inst[1:0] != 2'b11)
                  || ((op == OP_REG) && !(inst[31:25] inside {7'b0000000, 7'b0100000}));
`else
  assign illegal_c = 1'b0;
`endif

  dec_t out_reg,  out_next;
  dec_t skid_reg, skid_next;
  logic out_valid_reg,  out_valid_next;
  logic skid_valid_reg, skid_valid_next;
  logic accept;
  logic retire;

  assign accept = bus.in_valid && !skid_valid_reg;
  assign retire = out_valid_reg && bus.out_ready;

  // Skid can only fill while the output register is full, so an empty output
  // register implies an empty skid.
  always_comb begin
    out_next        = out_reg;
    skid_next       = skid_reg;
    out_valid_next  = out_valid_reg;
    skid_valid_next = skid_valid_reg;
    if (flush) begin
      out_valid_next  = 1'b0;
      skid_valid_next = 1'b0;
    end else if (!out_valid_reg || retire) begin
      if (skid_valid_reg) begin
        out_next        = skid_reg;
        out_valid_next  = 1'b1;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        out_next       = dec;
        out_valid_next = 1'b1;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (accept) begin
      skid_next       = dec;
      skid_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg        <= '0;
      skid_reg       <= '0;
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else begin
      out_reg        <= out_next;
      skid_reg       <= skid_next;
      out_valid_reg  <= out_valid_next;
      skid_valid_reg <= skid_valid_next;
    end
  end

  assign bus.in_ready  = !skid_valid_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.pc_out    = out_reg.pc;
  assign bus.opcode    = out_reg.opcode;
  assign bus.rd        = out_reg.rd;
  assign bus.rs1       = out_reg.rs1;
  assign bus.rs2       = out_reg.rs2;
  assign bus.funct3    = out_reg.funct3;
  assign bus.funct7    = out_reg.funct7;
  assign bus.imm       = out_reg.imm;
  assign bus.fmt       = out_reg.fmt;
  assign bus.illegal   = out_reg.illegal;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Directed self-checking bench for inst_decode_stage (XLEN=32).
// Expected illegal flags follow DECODE_ILLEGAL_CHECK_EN when it is defined.
module tb_inst_decode_stage;

`ifdef DECODE_ILLEGAL_CHECK_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic flush;
  int   compared;
  int   mismatched;
  logic [31:0] retired[$];

  inst_decode_stage_if #(.XLEN(32)) bus ();

  inst_decode_stage #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every retired entry; sampling mid-cycle sees the values the edge will use.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      retired.push_back(bus.pc_out);
      $display("retire pc=%08h fmt=%0d imm=%08h", bus.pc_out, bus.fmt, bus.imm);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] p);
    bus.in_valid = 1'b1;
    bus.inst_in  = i;
    bus.pc_in    = p;
    tick();
    bus.in_valid = 1'b0;
    $display("send pc=%08h inst=%08h", p, i);
  endtask

  task automatic check_dec(input string tag, input logic [2:0] f, input logic [4:0] r_d,
                           input logic [4:0] r_s1, input logic [4:0] r_s2,
                           input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] im, input logic ill);
    check({tag, ".valid"},   bus.out_valid, 1'b1);
    check({tag, ".fmt"},     bus.fmt, f);
    check({tag, ".rd"},      bus.rd, r_d);
    check({tag, ".rs1"},     bus.rs1, r_s1);
    check({tag, ".rs2"},     bus.rs2, r_s2);
    check({tag, ".funct3"},  bus.funct3, f3);
    check({tag, ".funct7"},  bus.funct7, f7);
    check({tag, ".imm"},     bus.imm, im);
    check({tag, ".illegal"}, bus.illegal, ill);
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.inst_in   = '0;
    bus.pc_in     = '0;
    bus.out_ready = 1'b1;

    repeat (3) tick();
    check("rst.out_valid", bus.out_valid, 1'b0);
    check("rst.in_ready",  bus.in_ready, 1'b1);
    check("rst.pc_out",    bus.pc_out, 32'h0);
    check("rst.imm",       bus.imm, 32'h0);
    check("rst.fmt",       bus.fmt, 3'd0);
    rst_n = 1'b1;
    tick();

    // Single beats with out_ready=1: each result appears one edge after accept.
    send(32'hFFB10093, 32'h1000);
    check_dec("addi", 3'd1, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFB, 1'b0);
    check("addi.pc", bus.pc_out, 32'h1000);
    check("addi.opcode", bus.opcode, 7'b0010011);
    send(32'h123451B7, 32'h1004);
    check_dec("lui", 3'd4, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b0);
    send(32'h00512423, 32'h1008);
    check_dec("sw", 3'd2, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'h00000008, 1'b0);
    check("sw.opcode", bus.opcode, 7'b0100011);
    send(32'hFE208EE3, 32'h100C);
    check_dec("beq", 3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b0);
    send(32'hFFDFF0EF, 32'h1010);
    check_dec("jal", 3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b0);
    send(32'h40000033, 32'h1014);
    check_dec("sub", 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h20, 32'h0, 1'b0);
    send(32'h20000033, 32'h1018);
    check_dec("badr", 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h10, 32'h0, ILL_EN);
    send(32'h0000007F, 32'h101C);
    check_dec("unk", 3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, ILL_EN);
    tick();
    check("idle.out_valid", bus.out_valid, 1'b0);

    // Back-pressure: out_ready low across three edges while four beats queue up.
    retired.delete();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.inst_in   = 32'hFFB10093;
    bus.pc_in     = 32'h0;
    tick();
    check("bp.in_ready1", bus.in_ready, 1'b1);
    check("bp.pc0", bus.pc_out, 32'h0);
    bus.pc_in = 32'h4;
    tick();
    check("bp.in_ready2", bus.in_ready, 1'b0);
    check("bp.hold0", bus.pc_out, 32'h0);
    bus.pc_in = 32'h8;
    tick();
    check("bp.stable", bus.pc_out, 32'h0);
    check("bp.in_ready3", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    check("bp.pc4", bus.pc_out, 32'h4);
    check("bp.in_ready4", bus.in_ready, 1'b1);
    tick();
    check("bp.pc8", bus.pc_out, 32'h8);
    bus.pc_in = 32'hC;
    tick();
    check("bp.pcC", bus.pc_out, 32'hC);
    bus.in_valid = 1'b0;
    tick();
    check("bp.drain", bus.out_valid, 1'b0);
    check("bp.count", retired.size(), 4);
    for (int k = 0; k < 4 && k < retired.size(); k++) begin
      check($sformatf("bp.order%0d", k), retired[k], 32'(4 * k));
    end

    // Flush with output register and skid both full plus a beat on the input.
    retired.delete();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.pc_in     = 32'h100;
    tick();
    bus.pc_in = 32'h104;
    tick();
    check("fl.full", bus.in_ready, 1'b0);
    bus.pc_in = 32'h108;
    flush     = 1'b1;
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("fl.out_valid", bus.out_valid, 1'b0);
    check("fl.in_ready",  bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    repeat (3) tick();
    check("fl.still_empty", bus.out_valid, 1'b0);
    check("fl.no_retire", retired.size(), 0);
    send(32'h123451B7, 32'h200);
    check("fl.recover", bus.pc_out, 32'h200);

    // Full-rate streaming: one beat per cycle, in_ready never drops.
    bus.in_valid = 1'b1;
    bus.inst_in  = 32'h00512423;
    for (int k = 0; k < 4; k++) begin
      bus.pc_in = 32'h300 + 32'(4 * k);
      tick();
      check($sformatf("tp.in_ready%0d", k), bus.in_ready, 1'b1);
      check($sformatf("tp.pc%0d", k), bus.pc_out, 32'h300 + 32'(4 * k));
    end
    bus.in_valid = 1'b0;
    tick();
    check("tp.drain", bus.out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/inst_decode_stage.md
Name: inst_decode_stage

Overview:
- Registered RV32I decode stage between fetch and register-read/execute.
- Accepts one 32-bit instruction and its PC per valid/ready handshake.
- Decodes all six base formats (R, I, S, B, U, J) and emits fields plus a fully assembled, sign-extended XLEN-wide immediate.
- Two-entry output/skid buffer gives full throughput under back-pressure; flush input supports branch redirect.

Parameters:
- XLEN, 32, datapath width of pc_in/pc_out/imm (32 or 64); immediates sign-extend to XLEN.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all held entries and the input beat of this cycle
- in_valid  in  1  fetch beat valid
- in_ready  out  1  stage can accept a beat
- inst_in  in  32  raw instruction
- pc_in  in  XLEN  instruction address
- out_valid  out  1  decoded entry valid
- out_ready  in  1  downstream accepts entry
- pc_out  out  XLEN  PC of decoded entry
- opcode  out  7  inst[6:0]
- rd, rs1, rs2  out  5 each  register indices; 0 when unused by format
- funct3  out  3  0 when unused (U, J)
- funct7  out  7  inst[31:25] for R only, else 0
- imm  out  XLEN  assembled, sign-extended immediate; 0 for R
- fmt  out  3  0=R 1=I 2=S 3=B 4=U 5=J 7=unknown
- illegal  out  1  unknown opcode (see Optional Feature)

Behaviour:
- Reset (async assert, sync deassert): out_valid=0, skid empty, every registered output 0, in_ready=1.
- Opcode map:
  - I: 0000011, 0010011, 1100111, 1110011, 0001111
  - S: 0100011
  - R: 0110011
  - B: 1100011
  - U: 0110111, 0010111
  - J: 1101111
  - anything else -> fmt=7, all fields 0.
- Immediates: I = inst[31:20]; S = {inst[31:25],inst[11:7]}; B = {inst[31],inst[7],inst[30:25],inst[11:8],0}; U = {inst[31:12],12'b0}; J = {inst[31],inst[19:12],inst[20],inst[30:21],0}. All sign-extended from inst[31] to XLEN.
- Decode is combinational on inst_in; the result is registered. Latency: accept at edge N -> out_valid at N+1.
- Handshakes: beat transfers on in_valid&&in_ready; entry retires on out_valid&&out_ready.
- in_ready = !skid_valid, driven from a register with no combinational path from out_ready.
- Accept while the output register is empty or retiring -> beat goes to the output register.
- Accept while the output register holds and does not retire -> beat goes to skid.
- Retire with skid full -> skid moves to the output register; skid empties.
- Order is strictly preserved. Sustained throughput is 1/cycle with out_ready=1.
- Outputs are stable while out_valid&&!out_ready.
- flush (priority over everything): next edge out_valid=0, skid empty, in_ready=1; an input beat in the flush cycle is dropped. Registered data fields may hold stale values.
- Simultaneous accept and retire with skid empty: new beat goes straight to the output register.

Optional Feature:
- Macro DECODE_ILLEGAL_CHECK_EN.
- Defined:
  - illegal=1 registered with fmt=7 for unknown opcodes.
  - illegal=1 also for inst[1:0]!=2'b11 (compressed / invalid).
  - illegal=1 for R-type with funct7 not in {0000000, 0100000}.
- Undefined: illegal tied to 0; fmt=7 still reported for unknown opcodes.

Test Plan:
- Single beats, out_ready=1:
  - 0xFFB10093 -> N+1: fmt=1, rd=1, rs1=2, funct3=0, imm=0xFFFFFFFB.
  - 0x123451B7 -> fmt=4, rd=3, imm=0x12345000.
- 0x00512423 (sw x5,8(x2)) -> fmt=2, rs1=2, rs2=5, rd=0, imm=0x00000008, funct7=0.
- 0xFE208EE3 (beq x1,x2,-4) -> fmt=3, rs1=1, rs2=2, imm=0xFFFFFFFC. Repeat with XLEN=64 -> imm=0xFFFFFFFFFFFFFFFC.
- Back-pressure: 4 consecutive beats, out_ready=0 for 3 cycles -> in_ready=0 after second accept, no beat lost or duplicated, PCs emerge in order 0x0, 0x4, 0x8, 0xC.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1; no flushed PC ever appears on pc_out.
- 0x0000007F -> fmt=7, all fields 0; illegal=1 with DECODE_ILLEGAL_CHECK_EN, illegal=0 without. 0x40000033 with macro -> illegal=0; 0x20000033 -> illegal=1.
